// File: rtl/cache_lookup_ctrl.sv
// cache_lookup_ctrl: sequencing controller for a 4-way, 128-set cache tag store.
// Accepts one CPU lookup at a time. On a miss it picks a victim way, issues a
// line-fill read burst, streams fill strobes to the data store and commits the
// new tag.
// Optional feature macro: PLRU_EN selects a 3-bit tree pseudo-LRU per set.
// When PLRU_EN is undefined, a 2-bit round-robin pointer per set is used.
module cache_lookup_ctrl #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 7,
  parameter int BEATS  = 16,
  parameter int TAG_W  = ADDR_W - IDX_W - 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ADDR_W-1:0]        i_req_addr,
  input  logic                     i_flush,
  output logic                     o_resp_valid,
  output logic                     o_resp_hit,
  output logic [1:0]               o_resp_way,
  output logic [IDX_W-1:0]         o_tag_index,
  input  logic [TAG_W-1:0]         i_tag_rd_0,
  input  logic [TAG_W-1:0]         i_tag_rd_1,
  input  logic [TAG_W-1:0]         i_tag_rd_2,
  input  logic [TAG_W-1:0]         i_tag_rd_3,
  output logic                     o_tag_we,
  output logic [IDX_W-1:0]         o_tag_wr_index,
  output logic [1:0]               o_tag_wr_way,
  output logic [TAG_W-1:0]         o_tag_wr_tag,
  output logic                     o_mem_arvalid,
  input  logic                     i_mem_arready,
  output logic [ADDR_W-1:0]        o_mem_araddr,
  output logic [7:0]               o_mem_arlen,
  input  logic                     i_mem_rvalid,
  input  logic                     i_mem_rlast,
  output logic                     o_mem_rready,
  output logic                     o_fill_we,
  output logic [1:0]               o_fill_way,
  output logic [IDX_W-1:0]         o_fill_index,
  output logic [$clog2(BEATS)-1:0] o_fill_beat
);

  localparam int OFF_W  = 6;
  localparam int SETS   = 2**IDX_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_AR, S_FILL, S_UPDATE, S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_armed;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_victim;
  logic               r_respHit;
  logic [1:0]         r_respWay;
  logic [BEAT_W-1:0]  r_beat;
  logic [3:0]         r_valid [SETS];

  logic [TAG_W-1:0]   w_tagRd [4];
  logic [3:0]         w_hitVec;
  logic               w_hit;
  logic [1:0]         w_hitWay;
  logic [1:0]         w_invWay;
  logic               w_anyInvalid;
  logic [1:0]         w_policyWay;
  logic [1:0]         w_victim;
  logic               w_accept;
  logic               w_unusedOffset;

  assign w_tagRd[0] = i_tag_rd_0;
  assign w_tagRd[1] = i_tag_rd_1;
  assign w_tagRd[2] = i_tag_rd_2;
  assign w_tagRd[3] = i_tag_rd_3;

  // Byte offset within the line never affects the lookup.
  assign w_unusedOffset = ^i_req_addr[OFF_W-1:0];

  // Per-way hit: line must be valid and its stored tag must match.
  always_comb begin
    w_hitVec = '0;
    for (int w = 0; w < 4; w++) begin
      w_hitVec[w] = r_valid[r_idx][w] & (w_tagRd[w] == r_tag);
    end
  end

  // Lowest-numbered hit way and lowest-numbered invalid way.
  always_comb begin
    w_hitWay = '0;
    w_invWay = '0;
    for (int w = 3; w >= 0; w--) begin
      if (w_hitVec[w])        w_hitWay = 2'(w);
      if (!r_valid[r_idx][w]) w_invWay = 2'(w);
    end
  end

  assign w_hit        = |w_hitVec;
  assign w_anyInvalid = ~&r_valid[r_idx];
  assign w_victim     = w_anyInvalid ? w_invWay : w_policyWay;
  assign w_accept     = (r_state == S_IDLE) & r_armed & ~i_flush & i_req_valid;

`ifdef PLRU_EN
  // bit0: 1 -> victim in ways 2/3; bit1 picks within 0/1; bit2 picks within 2/3.
  logic [2:0] r_plru [SETS];

  function automatic logic [2:0] plruTouch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] n;
    n = bits;
    if (!way[1]) begin
      n[0] = 1'b1;
      n[1] = ~way[0];
    end else begin
      n[0] = 1'b0;
      n[2] = ~way[0];
    end
    return n;
  endfunction

  assign w_policyWay = r_plru[r_idx][0] ? {1'b1, r_plru[r_idx][2]} : {1'b0, r_plru[r_idx][1]};

  // Tree points away from the most recently used way, on hits and on fills.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else if (r_state == S_LOOKUP && w_hit) begin
      r_plru[r_idx] <= plruTouch(r_plru[r_idx], w_hitWay);
    end else if (r_state == S_UPDATE) begin
      r_plru[r_idx] <= plruTouch(r_plru[r_idx], r_victim);
    end
  end
`else
  logic [1:0] r_rrPtr [SETS];

  assign w_policyWay = r_rrPtr[r_idx];

  // Round-robin pointer advances once per completed fill, never on hits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) r_rrPtr[s] <= '0;
    end else if (r_state == S_UPDATE) begin
      r_rrPtr[r_idx] <= r_rrPtr[r_idx] + 2'd1;
    end
  end
`endif

  // Valid bits: flush wipes everything while idle, a committed fill sets one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if (r_state == S_IDLE && i_flush) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else if (r_state == S_UPDATE) begin
      r_valid[r_idx][r_victim] <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Request capture, lookup result, victim choice and fill beat counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed   <= 1'b0;
      r_tag     <= '0;
      r_idx     <= '0;
      r_victim  <= '0;
      r_respHit <= 1'b0;
      r_respWay <= '0;
      r_beat    <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_tag <= i_req_addr[ADDR_W-1 -: TAG_W];
        r_idx <= i_req_addr[OFF_W +: IDX_W];
      end
      if (r_state == S_LOOKUP) begin
        r_respHit <= w_hit;
        if (w_hit) r_respWay <= w_hitWay;
        else       r_victim  <= w_victim;
      end
      if (r_state == S_MISS_AR && i_mem_arready) r_beat <= '0;
      if (r_state == S_FILL && i_mem_rvalid && r_beat != LAST_BEAT) r_beat <= r_beat + 1'b1;
      if (r_state == S_UPDATE) r_respWay <= r_victim;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_nextState   = r_state;
    o_req_ready   = 1'b0;
    o_resp_valid  = 1'b0;
    o_tag_we      = 1'b0;
    o_mem_arvalid = 1'b0;
    o_mem_rready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = r_armed & ~i_flush;
        if (w_accept) w_nextState = S_LOOKUP;
      end
      S_LOOKUP:  w_nextState = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_AR: begin
        o_mem_arvalid = 1'b1;
        if (i_mem_arready) w_nextState = S_FILL;
      end
      S_FILL: begin
        o_mem_rready = 1'b1;
        if (i_mem_rvalid && i_mem_rlast) w_nextState = S_UPDATE;
      end
      S_UPDATE: begin
        o_tag_we    = 1'b1;
        w_nextState = S_RESP;
      end
      S_RESP: begin
        o_resp_valid = 1'b1;
        w_nextState  = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  assign o_resp_hit     = r_respHit;
  assign o_resp_way     = r_respWay;
  assign o_tag_index    = r_idx;
  assign o_tag_wr_index = r_idx;
  assign o_tag_wr_way   = r_victim;
  assign o_tag_wr_tag   = r_tag;
  assign o_mem_araddr   = {r_tag, r_idx, OFF_W'(0)};
  assign o_mem_arlen    = 8'(BEATS-1);
  assign o_fill_we      = o_mem_rready & i_mem_rvalid;
  assign o_fill_way     = r_victim;
  assign o_fill_index   = r_idx;
  assign o_fill_beat    = r_beat;

endmodule
